alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_op_decode.sv | 37 +++
 rtl/alu_exec_unit.sv | 178 +++++++++++++++++
 tb/tb_alu_exec_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit and the main decoder:
// operation codes, instruction opcode constants and sequencer state encoding.
package alu_pkg;

    typedef enum logic [3:0] {
        AluAnd     = 4'b0000,
        AluOrr     = 4'b0001,
        AluAdd     = 4'b0010,
        AluMul     = 4'b0011,
        AluSub     = 4'b0110,
        AluPassB   = 4'b0111,
        AluLsl     = 4'b1000,
        AluLsr     = 4'b1001,
        AluIllegal = 4'b1111
    } alu_op_e;

    localparam logic [10:0] OpcAdd = 11'b10001011000;
    localparam logic [10:0] OpcSub = 11'b11001011000;
    localparam logic [10:0] OpcAnd = 11'b10001010000;
    localparam logic [10:0] OpcOrr = 11'b10101010000;
    localparam logic [10:0] OpcMul = 11'b10011011000;
    localparam logic [10:0] OpcLsl = 11'b11010011011;
    localparam logic [10:0] OpcLsr = 11'b11010011010;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StMul  = 2'b01,
        StHold = 2'b10
    } alu_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU control decode: {ALUOp1, ALUOp0} plus instruction[31:21]
// into a 4-bit operation code and an illegal-opcode flag.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0]  alu_op_i,
    input  logic [10:0] opcode_i,
    output alu_op_e     op_code_o,
    output logic        illegal_o
);

    always_comb begin
        op_code_o = AluIllegal;
        illegal_o = 1'b0;
        if (alu_op_i == 2'b00) begin
            op_code_o = AluAdd;
        end else if (alu_op_i[0]) begin
            // Covers both 01 and 11.
            op_code_o = AluPassB;
        end else begin
            case (opcode_i)
                OpcAdd:  op_code_o = AluAdd;
                OpcSub:  op_code_o = AluSub;
                OpcAnd:  op_code_o = AluAnd;
                OpcOrr:  op_code_o = AluOrr;
                OpcMul:  op_code_o = AluMul;
                OpcLsl:  op_code_o = AluLsl;
                OpcLsr:  op_code_o = AluLsr;
                default: begin
                    op_code_o = AluIllegal;
                    illegal_o = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: valid/ready handshaked single-cycle ops plus an
// iterative shift-add multiplier retiring MUL_BITS multiplier bits per cycle.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned MUL_BITS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [10:0]      opcode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [3:0]       op_code,
    output logic             illegal
);

    localparam int unsigned Steps = WIDTH / MUL_BITS;
    localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    alu_op_e          op_code_q, op_code_d;
    logic             illegal_q, illegal_d;

    alu_op_e          dec_op;
    logic             dec_illegal;
    logic             accept;
    logic             mul_done;
    logic [WIDTH-1:0] single_res;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] mshift;
    logic [5:0]       shamt;
    logic             shift_oob;

    alu_op_decode u_decode (
        .alu_op_i  (alu_op),
        .opcode_i  (opcode),
        .op_code_o (dec_op),
        .illegal_o (dec_illegal)
    );

    assign accept   = in_valid & in_ready;
    assign mul_done = (state_q == StMul) && (cnt_q == LastCnt);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (dec_op == AluMul) ? StMul : StHold;
                end
            end
            StMul: begin
                if (mul_done) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (accept) begin
                    state_d = (dec_op == AluMul) ? StMul : StHold;
                end else if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake and result outputs
    always_comb begin
        out_valid = (state_q == StHold);
        // Reset is asynchronous, so gate ready directly with it.
        in_ready  = rst_n & ((state_q == StIdle) | ((state_q == StHold) & out_ready));
        result    = result_q;
        zero      = (result_q == '0);
        op_code   = op_code_q;
        illegal   = illegal_q;
    end

    // Single-cycle operations, computed from the live inputs at acceptance
    always_comb begin
        shamt      = op_b[5:0];
        shift_oob  = (32'(shamt) >= WIDTH);
        single_res = '0;
        case (dec_op)
            AluAdd:   single_res = op_a + op_b;
            AluSub:   single_res = op_a - op_b;
            AluAnd:   single_res = op_a & op_b;
            AluOrr:   single_res = op_a | op_b;
            AluPassB: single_res = op_b;
            AluLsl:   single_res = shift_oob ? '0 : (op_a << shamt);
            AluLsr:   single_res = shift_oob ? '0 : (op_a >> shamt);
            default:  single_res = '0;
        endcase
    end

    // One multiplier digit: sum of the shifted multiplicand copies it selects
    always_comb begin
        partial = '0;
        mshift  = '0;
        for (int unsigned j = 0; j < MUL_BITS; j++) begin
            mshift = mplier_q >> j;
            if (mshift[0]) begin
                partial = partial + (mcand_q << j);
            end
        end
    end

    always_comb begin
        result_d  = result_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        op_code_d = op_code_q;
        illegal_d = illegal_q;

        if (state_q == StMul) begin
            result_d = result_q + partial;
            mcand_d  = mcand_q << MUL_BITS;
            mplier_d = mplier_q >> MUL_BITS;
            cnt_d    = mul_done ? '0 : cnt_q + CntW'(1);
        end

        if (accept) begin
            op_code_d = dec_op;
            illegal_d = dec_illegal;
            cnt_d     = '0;
            if (dec_op == AluMul) begin
                result_d = '0;
                mcand_d  = op_a;
                mplier_d = op_b;
            end else begin
                result_d = single_res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q  <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            op_code_q <= AluAnd;  // encodes as 4'b0000
            illegal_q <= 1'b0;
        end else begin
            result_q  <= result_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            op_code_q <= op_code_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (WIDTH=64, MUL_BITS=1) against a
// behavioural model of the ALU operations and handshake timing.
module tb_alu_exec_unit;

    localparam int unsigned W = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    alu_op = 2'b00;
    logic [10:0]   opcode = '0;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic          zero;
    logic [3:0]    op_code;
    logic          illegal;

    int n_checks = 0;
    int n_pass   = 0;

    alu_exec_unit #(.WIDTH(W), .MUL_BITS(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .opcode    (opcode),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .op_code   (op_code),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference behaviour straight from the operation table.
    function automatic void model(input logic [1:0] aop, input logic [10:0] opc,
                                  input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic [3:0] code,
                                  output logic ill, output int lat);
        ill = 1'b0;
        lat = 1;
        if (aop == 2'b00) begin
            r = a + b; code = 4'b0010;
        end else if (aop == 2'b01 || aop == 2'b11) begin
            r = b; code = 4'b0111;
        end else begin
            case (opc)
                11'b10001011000: begin r = a + b; code = 4'b0010; end
                11'b11001011000: begin r = a - b; code = 4'b0110; end
                11'b10001010000: begin r = a & b; code = 4'b0000; end
                11'b10101010000: begin r = a | b; code = 4'b0001; end
                11'b10011011000: begin r = a * b; code = 4'b0011; lat = W + 1; end
                11'b11010011011: begin r = a << b[5:0]; code = 4'b1000; end
                11'b11010011010: begin r = a >> b[5:0]; code = 4'b1001; end
                default:         begin r = 64'd0; code = 4'b1111; ill = 1'b1; end
            endcase
        end
    endfunction

    // Issue one request from idle, check latency, busy window, outputs and an
    // optional stall with out_ready low.
    task automatic run_op(input string tag, input logic [1:0] aop, input logic [10:0] opc,
                          input logic [63:0] a, input logic [63:0] b, input int stall);
        logic [63:0] er;
        logic [3:0]  ec;
        logic        ei;
        int          el;
        int          w;
        int          lat;
        int          busy;
        model(aop, opc, a, b, er, ec, ei, el);
        alu_op = aop; opcode = opc; op_a = a; op_b = b;
        in_valid = 1'b1; out_ready = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin @(negedge clk); w++; end
        check({tag, "_accept_timeout"}, 64'(w < 200), 64'd1);
        @(negedge clk);
        // Operands must already be captured; scramble them.
        in_valid = 1'b0;
        op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
        opcode = 11'($urandom); alu_op = 2'($urandom);
        lat = 1; busy = 0;
        while (!out_valid && lat < 200) begin
            if (!in_ready) busy++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(el));
        check({tag, "_busy_cycles"}, 64'(busy), 64'(el - 1));
        check({tag, "_result"}, result, er);
        check({tag, "_zero"}, 64'(zero), 64'(er == 64'd0));
        check({tag, "_op_code"}, 64'(op_code), 64'(ec));
        check({tag, "_illegal"}, 64'(illegal), 64'(ei));
        if (stall > 0) begin
            out_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
                check({tag, "_stall_result"}, result, er);
                check({tag, "_stall_ready"}, 64'(in_ready), 64'd0);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        check({tag, "_drained"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] ra [4];
        logic [63:0] rb [4];
        logic [63:0] x;
        logic [63:0] y;
        logic [10:0] opcs [7];
        int          nv;
        opcs[0] = 11'b10001011000; opcs[1] = 11'b11001011000; opcs[2] = 11'b10001010000;
        opcs[3] = 11'b10101010000; opcs[4] = 11'b10011011000; opcs[5] = 11'b11010011011;
        opcs[6] = 11'b11010011010;

        // Reset values while held in reset
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_zero", 64'(zero), 64'd1);
        check("rst_op_code", 64'(op_code), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Directed cases
        run_op("add_5_7", 2'b10, opcs[0], 64'd5, 64'd7, 0);
        run_op("sub_eq", 2'b10, opcs[1], 64'd3, 64'd3, 0);
        run_op("sub_wrap", 2'b10, opcs[1], 64'd0, 64'd1, 1);
        run_op("mul_dir", 2'b10, opcs[4], 64'hFFFF_FFFF, 64'd3, 0);
        run_op("illegal", 2'b10, 11'h7FF, 64'h1234, 64'h5678, 0);
        run_op("passb", 2'b01, 11'h7FF, 64'h1234, 64'h5678, 0);
        run_op("alu00_add", 2'b00, opcs[1], 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0);
        run_op("lsl_63", 2'b10, opcs[5], 64'd3, 64'd63, 0);
        run_op("lsr_63", 2'b10, opcs[6], 64'h8000_0000_0000_0000, 64'hFFC0_0000_0000_003F, 0);

        // Four back-to-back ORRs, then backpressure
        for (int i = 0; i < 4; i++) begin
            ra[i] = {$urandom, $urandom};
            rb[i] = {$urandom, $urandom};
        end
        alu_op = 2'b10; opcode = opcs[3]; op_a = ra[0]; op_b = rb[0];
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b2b_valid", 64'(out_valid), 64'd1);
            check("b2b_result", result, ra[i] | rb[i]);
            if (i < 3) begin
                op_a = ra[i + 1]; op_b = rb[i + 1];
            end else begin
                opcode = opcs[0]; op_a = 64'd1; op_b = 64'd1;
                out_ready = 1'b0;
            end
        end
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_result", result, ra[3] | rb[3]);
            check("bp_op_code", 64'(op_code), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("bp_drained", 64'(out_valid), 64'd0);

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            int k;
            logic [1:0] aop;
            logic [10:0] opc;
            k = int'($urandom_range(0, 12));
            x = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 15)) : {$urandom, $urandom};
            y = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 15)) : {$urandom, $urandom};
            aop = 2'b10;
            opc = opcs[k % 7];
            if (k == 4 && $urandom_range(0, 2) != 0) opc = opcs[3];
            if (k == 7) begin aop = 2'b00; opc = 11'($urandom); end
            if (k == 8) begin aop = 2'b11; opc = 11'($urandom); end
            if (k >= 9) opc = 11'($urandom);
            run_op("rand", aop, opc, x, y, int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a multiplication
        alu_op = 2'b10; opcode = opcs[4]; op_a = 64'hFFFF_FFFF; op_b = 64'd3;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        check("mid_mul_busy", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_result", result, 64'd0);
        check("arst_zero", 64'(zero), 64'd1);
        check("arst_op_code", 64'(op_code), 64'd0);
        check("arst_illegal", 64'(illegal), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_release_ready", 64'(in_ready), 64'd1);
        nv = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        check("arst_no_valid", 64'(nv), 64'd0);
        run_op("after_rst_add", 2'b10, opcs[0], 64'd40, 64'd2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
